// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD down timer.
// Optional clamp of invalid preset digits: BCD_DOWN_TIMER_INVALID_CLAMP_EN.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_t;

   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam logic [3:0] DIGIT_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit decrement stage; chained through the borrow.
// Digits above 9 decrement as plain binary until they are back in range.
module bcd_digit_dec
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   input  logic       dec,
   output logic [3:0] q,
   output logic       bout
);

   always_comb begin
      q    = d;
      bout = 1'b0;
      if (dec) begin
         if (d == DIGIT_MIN) begin
            q    = DIGIT_MAX;
            bout = 1'b1;
         end else begin
            q = d - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down timer with load/start/pause and optional auto reload.
// Define BCD_DOWN_TIMER_INVALID_CLAMP_EN to clamp preset digits above 9.
module bcd_down_timer
   import bcd_pkg::*;
#(
   parameter int AUTO_RELOAD = 0
) (
   input  logic       CLK,
   input  logic       Clear,
   input  logic       load,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_units,
   input  logic       start,
   input  logic       pause,
   input  logic       tick,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       borrow,
   output logic       done,
   output logic       busy
);

   state_t     state, state_n;
   logic [3:0] tens_n, units_n;
   logic [3:0] pre_t, pre_u, pre_t_n, pre_u_n;
   logic [3:0] ld_t, ld_u;
   logic [3:0] dec_t, dec_u;
   logic       borrow_n, done_n;
   logic       terminal, dec_en, ub, unused_tb;

`ifdef BCD_DOWN_TIMER_INVALID_CLAMP_EN
   assign ld_t = (preset_tens  > DIGIT_MAX) ? DIGIT_MAX : preset_tens;
   assign ld_u = (preset_units > DIGIT_MAX) ? DIGIT_MAX : preset_units;
`else
   assign ld_t = preset_tens;
   assign ld_u = preset_units;
`endif

   // 01 (or a reloaded 00) ends the run instead of decrementing
   assign terminal = (tens == DIGIT_MIN) && (units <= 4'd1);
   assign dec_en   = (state == RUN) && !load && !pause
                     && tick && !terminal;

   bcd_digit_dec u_units (
      .d    (units),
      .dec  (dec_en),
      .q    (dec_u),
      .bout (ub)
   );

   bcd_digit_dec u_tens (
      .d    (tens),
      .dec  (ub),
      .q    (dec_t),
      .bout (unused_tb)
   );

   always_comb begin
      state_n  = state;
      tens_n   = tens;
      units_n  = units;
      pre_t_n  = pre_t;
      pre_u_n  = pre_u;
      borrow_n = 1'b0;
      done_n   = 1'b0;
      if (load) begin
         tens_n  = ld_t;
         units_n = ld_u;
         pre_t_n = ld_t;
         pre_u_n = ld_u;
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  if ({tens, units} != 8'h00) begin
                     state_n = RUN;
                  end else begin
                     state_n = DONE;
                     done_n  = 1'b1;
                  end
               end
            end
            RUN: begin
               if (pause) begin
                  state_n = PAUSED;
               end else if (tick) begin
                  if (terminal) begin
                     done_n = 1'b1;
                     if (AUTO_RELOAD != 0) begin
                        tens_n  = pre_t;
                        units_n = pre_u;
                     end else begin
                        tens_n  = DIGIT_MIN;
                        units_n = DIGIT_MIN;
                        state_n = DONE;
                     end
                  end else begin
                     tens_n   = dec_t;
                     units_n  = dec_u;
                     borrow_n = ub;
                  end
               end
            end
            PAUSED: begin
               if (start && !pause) state_n = RUN;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state  <= IDLE;
         tens   <= DIGIT_MIN;
         units  <= DIGIT_MIN;
         pre_t  <= DIGIT_MIN;
         pre_u  <= DIGIT_MIN;
         borrow <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         tens   <= tens_n;
         units  <= units_n;
         pre_t  <= pre_t_n;
         pre_u  <= pre_u_n;
         borrow <= borrow_n;
         done   <= done_n;
      end
   end

   assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: one plain and one auto-reload instance
// checked every cycle against an integer model plus literal pins.
module tb_bcd_down_timer;

   logic       CLK = 1'b0;
   logic       Clear = 1'b0;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
   logic [3:0] preset_tens = 4'd0, preset_units = 4'd0;
   logic [3:0] tens0, units0, tens1, units1;
   logic       borrow0, done0, busy0, borrow1, done1, busy1;

   int n_chk = 0;
   int n_fail = 0;
   bit model_on = 1'b1;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int m_cnt[2]  = '{0, 0};
   int m_mode[2] = '{0, 0};
   bit m_b[2]    = '{0, 0};
   bit m_d[2]    = '{0, 0};
   int m_pre = 0;
   int pin;

   always #5 CLK = ~CLK;

   bcd_down_timer #(.AUTO_RELOAD(0)) dut (
      .CLK(CLK), .Clear(Clear), .load(load),
      .preset_tens(preset_tens), .preset_units(preset_units),
      .start(start), .pause(pause), .tick(tick),
      .tens(tens0), .units(units0),
      .borrow(borrow0), .done(done0), .busy(busy0)
   );

   bcd_down_timer #(.AUTO_RELOAD(1)) dut_ar (
      .CLK(CLK), .Clear(Clear), .load(load),
      .preset_tens(preset_tens), .preset_units(preset_units),
      .start(start), .pause(pause), .tick(tick),
      .tens(tens1), .units(units1),
      .borrow(borrow1), .done(done1), .busy(busy1)
   );

   task automatic chk(input string nm, input logic [7:0] act,
                      input int exp);
      n_chk++;
      if (act !== 8'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Timer behaviour on the decimal value of the count
   always @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_mode[k] = M_IDLE;
            m_b[k] = 0; m_d[k] = 0;
         end
         m_pre = 0;
      end else begin
         pin = int'(preset_tens) * 10 + int'(preset_units);
         for (int k = 0; k < 2; k++) begin
            m_b[k] = 0;
            m_d[k] = 0;
            if (load) begin
               m_cnt[k] = pin;
               m_mode[k] = M_IDLE;
            end else begin
               case (m_mode[k])
                  M_IDLE, M_DONE:
                     if (start) begin
                        if (m_cnt[k] != 0) m_mode[k] = M_RUN;
                        else begin
                           m_mode[k] = M_DONE;
                           m_d[k] = 1;
                        end
                     end
                  M_RUN:
                     if (pause) m_mode[k] = M_PAUSE;
                     else if (tick) begin
                        if (m_cnt[k] <= 1) begin
                           m_d[k] = 1;
                           if (k == 1) m_cnt[k] = m_pre;
                           else begin
                              m_cnt[k] = 0;
                              m_mode[k] = M_DONE;
                           end
                        end else begin
                           m_b[k] = (m_cnt[k] % 10 == 0);
                           m_cnt[k] = m_cnt[k] - 1;
                        end
                     end
                  M_PAUSE:
                     if (start && !pause) m_mode[k] = M_RUN;
                  default: m_mode[k] = M_IDLE;
               endcase
            end
         end
         if (load) m_pre = pin;
      end
   end

   always @(negedge CLK) begin
      if (model_on) begin
         chk("tens0", tens0, m_cnt[0] / 10);
         chk("units0", units0, m_cnt[0] % 10);
         chk("borrow0", borrow0, int'(m_b[0]));
         chk("done0", done0, int'(m_d[0]));
         chk("busy0", busy0,
             int'(m_mode[0] == M_RUN || m_mode[0] == M_PAUSE));
         chk("tens1", tens1, m_cnt[1] / 10);
         chk("units1", units1, m_cnt[1] % 10);
         chk("borrow1", borrow1, int'(m_b[1]));
         chk("done1", done1, int'(m_d[1]));
         chk("busy1", busy1,
             int'(m_mode[1] == M_RUN || m_mode[1] == M_PAUSE));
      end
   end

   initial begin
      int nb, nd;
      logic [7:0] seq[7];
      seq = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};

      #1 Clear = 1'b1;
      #1;
      chk("rst_cnt", {tens0, units0}, 8'h00);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      #10 Clear = 1'b0;
      cyc(1);

      // 25 down to 00
      preset_tens = 4'd2; preset_units = 4'd5; load = 1;
      cyc(1);
      load = 0; start = 1;
      cyc(1);
      start = 0; tick = 1;
      nb = 0; nd = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1);
         nb += int'(borrow0);
         nd += int'(done0);
         if (i == 4) chk("t1_20", {tens0, units0}, 8'h20);
         if (i == 5) begin
            chk("t1_19", {tens0, units0}, 8'h19);
            chk("t1_b19", borrow0, 1);
         end
      end
      chk("t1_nb", 8'(nb), 2);
      chk("t1_nd", 8'(nd), 1);
      chk("t1_cnt", {tens0, units0}, 8'h00);
      chk("t1_busy", busy0, 0);
      chk("t1_ar", {tens1, units1}, 8'h25);
      chk("t1_arbusy", busy1, 1);
      tick = 0;

      // auto reload from 03
      preset_tens = 4'd0; preset_units = 4'd3; load = 1;
      cyc(1);
      load = 0; start = 1;
      cyc(1);
      start = 0; tick = 1;
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         chk("t2_seq", {tens1, units1}, int'(seq[i]));
         chk("t2_done", done1, int'(i % 3 == 2));
         chk("t2_busy", busy1, 1);
      end
      chk("t2_busy0", busy0, 0);
      tick = 0;

      // pause / resume from 40
      preset_tens = 4'd4; preset_units = 4'd0; load = 1;
      cyc(1);
      load = 0; start = 1;
      cyc(1);
      start = 0; tick = 1;
      cyc(5);
      pause = 1;
      cyc(1);
      chk("t3_p35", {tens0, units0}, 8'h35);
      pause = 0;
      cyc(2);
      chk("t3_h35", {tens0, units0}, 8'h35);
      chk("t3_busy", busy0, 1);
      start = 1; tick = 0;
      cyc(1);
      start = 0;
      chk("t3_r35", {tens0, units0}, 8'h35);
      tick = 1;
      cyc(1);
      chk("t3_34", {tens0, units0}, 8'h34);
      tick = 0;
      preset_tens = 4'd5; preset_units = 4'd5; load = 1;
      cyc(1);
      load = 0;
      chk("t3_ld55", {tens0, units0}, 8'h55);
      chk("t3_abort", busy0, 0);

      // start with 00
      preset_tens = 4'd0; preset_units = 4'd0; load = 1;
      cyc(1);
      load = 0; start = 1;
      cyc(1);
      start = 0;
      chk("t4_done", done0, 1);
      chk("t4_done_ar", done1, 1);
      chk("t4_busy", busy0, 0);
      cyc(1);
      chk("t4_pulse", done0, 0);

      // async clear mid-run at 17
      preset_tens = 4'd2; preset_units = 4'd0; load = 1;
      cyc(1);
      load = 0; start = 1;
      cyc(1);
      start = 0; tick = 1;
      cyc(3);
      chk("t5_17", {tens0, units0}, 8'h17);
      #3 Clear = 1'b1;
      #1;
      chk("t5_clr", {tens0, units0}, 8'h00);
      chk("t5_busy", busy0, 0);
      tick = 0;
      #1 Clear = 1'b0;
      preset_tens = 4'd0; preset_units = 4'd9; load = 1;
      cyc(1);
      load = 0;
      chk("t5_09", {tens0, units0}, 8'h09);
      start = 1;
      cyc(1);
      start = 0; tick = 1;
      cyc(10);
      tick = 0;

      // invalid digits
      model_on = 0;
      preset_tens = 4'hC; preset_units = 4'hF; load = 1;
      cyc(1);
      load = 0;
`ifdef BCD_DOWN_TIMER_INVALID_CLAMP_EN
      chk("t6_ld", {tens0, units0}, 8'h99);
`else
      chk("t6_ld", {tens0, units0}, 8'hCF);
`endif
      start = 1;
      cyc(1);
      start = 0; tick = 1;
      cyc(1);
`ifdef BCD_DOWN_TIMER_INVALID_CLAMP_EN
      chk("t6_dec", {tens0, units0}, 8'h98);
`else
      chk("t6_dec", {tens0, units0}, 8'hCE);
`endif
      tick = 0;
      preset_tens = 4'd1; preset_units = 4'd2; load = 1;
      cyc(1);
      load = 0;
      model_on = 1;
      start = 1;
      cyc(1);
      start = 0; tick = 1;
      cyc(14);
      tick = 0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
